// File: rtl/and4_stim_gen.sv
// and4_stim_gen: stimulus generator for a downstream 4-input AND cell.
// It drives {IN4,IN3,IN2,IN1} with one of four vector patterns for NCYC cycles,
// then pulses DONE for one cycle.
// Optional feature macro: AND4_STIM_CHECK_EN. When it is defined, Q is compared
// against the AND of the previously driven vector and mismatches are counted
// in ERR_CNT. When it is undefined, Q is ignored and ERR_CNT is tied to zero.
// The internal FSM state leads the registered outputs by one cycle. FIN in the
// state register therefore shows up as the DONE pulse one edge later.
module and4_stim_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  IDLE_VAL  = 4'b0000
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        START,
    input  logic [1:0]  MODE,
    input  logic [15:0] NCYC,
    input  logic        Q,
    output logic        IN1,
    output logic        IN2,
    output logic        IN3,
    output logic        IN4,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  ERR_CNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    // Vector for index k in the selected mode. Only the low bits of k and the
    // LFSR state matter.
    function automatic logic [3:0] pattern(input logic [1:0] m, input logic [3:0] k,
                                           input logic [3:0] rnd);
        logic [3:0] v;
        case (m)
            2'd0:    v = k;
            2'd1:    v = rnd;
            2'd2:    v = k[0] ? (4'hF & ~(4'b0001 << k[2:1])) : 4'hF;
            2'd3:    v = 4'hF;
            default: v = 4'hF;
        endcase
        return v;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] ncyc_q, ncyc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_acc_s;

    // Next-state logic for the run sequencer and the registered cell inputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ncyc_d      = ncyc_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        vec_d       = IDLE_VAL;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        start_acc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    start_acc_s = 1'b1;
                    mode_d      = MODE;
                    ncyc_d      = NCYC;
                    cnt_d       = 16'd0;
                    lfsr_d      = SEED_EFF;
                    state_d     = (NCYC == 16'd0) ? ST_FIN : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                vec_d  = pattern(mode_q, cnt_q[3:0], lfsr_q[3:0]);
                busy_d = 1'b1;
                lfsr_d = lfsr_next(lfsr_q);
                if (cnt_q == (ncyc_q - 16'd1)) begin
                    state_d = ST_FIN;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            ncyc_q  <= 16'd0;
            cnt_q   <= 16'd0;
            lfsr_q  <= SEED_EFF;
            vec_q   <= IDLE_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ncyc_q  <= ncyc_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {IN4, IN3, IN2, IN1} = vec_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef AND4_STIM_CHECK_EN
    logic [7:0] err_q, err_d;

    // busy_q marks a cycle in which a vector was driven. Q at the closing edge
    // should therefore equal the AND of that vector.
    always_comb begin
        err_d = err_q;
        if (start_acc_s) begin
            err_d = 8'h00;
        end else if (busy_q && (Q != (&vec_q)) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'h01;
        end else begin
            err_d = err_q;
        end
    end

    // Mismatch counter register; it is cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            err_q <= 8'h00;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR_CNT = err_q;
`else
    // Without the check feature, Q has no load and the count stays zero.
    logic unused_q_s;
    logic unused_start_s;
    assign unused_q_s     = Q;
    assign unused_start_s = start_acc_s;
    assign ERR_CNT        = 8'h00;
`endif

endmodule

// File: tb/tb_and4_stim_gen.sv
// Scoreboard bench for and4_stim_gen: expected vectors are queued before each
// START and a negedge monitor pops and compares one per BUSY cycle.
module tb_and4_stim_gen;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] ncyc;
    logic        q;
    logic        in1, in2, in3, in4;
    logic        busy, done;
    logic [7:0]  err_cnt;
    logic        q_force0 = 1'b0;
    logic [3:0]  vec;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] cap_q[$];
    logic [3:0] run1_q[$];
    bit         cap_en = 1'b0;

    always #5 clk = ~clk;

    assign vec = {in4, in3, in2, in1};
    // Ideal AND4 cell, or a stuck-at-0 output for fault injection.
    assign q   = q_force0 ? 1'b0 : (in1 & in2 & in3 & in4);

    and4_stim_gen dut (
        .CLK(clk), .RSTB(rstb), .START(start), .MODE(mode), .NCYC(ncyc), .Q(q),
        .IN1(in1), .IN2(in2), .IN3(in3), .IN4(in4),
        .BUSY(busy), .DONE(done), .ERR_CNT(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: each BUSY cycle must present the next queued vector.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (cap_en) cap_q.push_back(vec);
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL vec_unexpected: got %0h expected none", vec);
            end else begin
                chk("vec", {28'd0, vec}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // Reference LFSR: Fibonacci taps 16,14,13,11, right shift.
    function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Issue one run, check BUSY count, DONE timing, and the return to idle.
    task automatic run(input logic [1:0] m, input logic [15:0] n, input int inj);
        int busy_n, done_n, done_idx;
        @(negedge clk);
        start = 1'b1; mode = m; ncyc = n;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; ncyc = 16'd5;
        busy_n = 0; done_n = 0; done_idx = -1;
        for (int j = 0; j < int'(n) + 8; j++) begin
            @(negedge clk);
            if (j == inj) start = 1'b1;
            else if (j == inj + 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_idx < 0) done_idx = j;
            end
        end
        chk("done_count", done_n, 1);
        chk("done_time", done_idx, int'(n) + 1);
        chk("busy_len", busy_n, int'(n));
        chk("idle_val", {28'd0, vec}, 32'd0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] l;
        int busy_n, done_n;
        logic [3:0] walk_tab [8] = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};

        // Reset with START held high: nothing may start.
        rstb = 1'b0; start = 1'b1; mode = 2'd0; ncyc = 16'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vec", {28'd0, vec}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);
        start = 1'b0; rstb = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Exhaustive, 20 vectors: 0..F then 0..3.
        for (int k = 0; k < 20; k++) exp_q.push_back(4'(k % 16));
        run(2'd0, 16'd20, -1);

        // Walking zero with the ideal cell on Q.
        for (int k = 0; k < 8; k++) exp_q.push_back(walk_tab[k]);
        run(2'd2, 16'd8, -1);
        chk("walk_err", {24'd0, err_cnt}, 32'd0);

        // Static pattern with Q stuck at 0: the count saturates.
        q_force0 = 1'b1;
        for (int k = 0; k < 300; k++) exp_q.push_back(4'hF);
        run(2'd3, 16'd300, -1);
`ifdef AND4_STIM_CHECK_EN
        chk("err_saturate", {24'd0, err_cnt}, 32'hFF);
`else
        chk("err_tied_zero", {24'd0, err_cnt}, 32'h0);
`endif
        q_force0 = 1'b0;

        // The next accepted START clears the count.
        exp_q.push_back(4'hF);
        @(negedge clk);
        start = 1'b1; mode = 2'd3; ncyc = 16'd1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("err_clear", {24'd0, err_cnt}, 32'h0);
        repeat (6) @(negedge clk);
        chk("short_queue", exp_q.size(), 0);

        // NCYC of zero produces DONE only.
        run(2'd0, 16'd0, -1);

        // START pulsed mid-run is ignored.
        for (int k = 0; k < 10; k++) exp_q.push_back(4'(k));
        run(2'd0, 16'd10, 4);

        // Random mode: model-predicted vectors, then a second run must match the first.
        l = 16'hACE1;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(l[3:0]);
            l = ref_lfsr(l);
        end
        cap_q.delete(); cap_en = 1'b1;
        run(2'd1, 16'd16, -1);
        run1_q = cap_q;
        cap_q.delete();
        chk("rnd_first", {28'd0, run1_q[0]}, 32'h1);
        l = 16'hACE1;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(l[3:0]);
            l = ref_lfsr(l);
        end
        run(2'd1, 16'd16, -1);
        cap_en = 1'b0;
        chk("rnd_len", cap_q.size(), 16);
        for (int k = 0; k < 16 && k < cap_q.size(); k++)
            chk("rnd_repeat", {28'd0, cap_q[k]}, {28'd0, run1_q[k]});

        // Reset mid-run aborts with no DONE.
        for (int k = 0; k < 10; k++) exp_q.push_back(4'(k));
        @(negedge clk);
        start = 1'b1; mode = 2'd0; ncyc = 16'd10;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rstb = 1'b0;
        @(negedge clk);
        chk("abort_vec", {28'd0, vec}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err", {24'd0, err_cnt}, 32'd0);
        exp_q.delete();
        #1 rstb = 1'b1;
        busy_n = 0; done_n = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) done_n++;
        end
        chk("abort_no_done", done_n, 0);
        chk("abort_no_busy", busy_n, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/and4_stim_gen.md
Name: and4_stim_gen

Overview:
- Sequential stimulus generator sitting directly upstream of a 4-input AND cell (IN1..IN4 -> Q) in the power-characterization test harness.
- Drives the cell's four inputs with a programmable vector sequence for a programmed number of cycles.
- Signals completion and optionally self-checks the cell's Q output.

Parameters:
- LFSR_SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced internally by 16'hACE1.
- IDLE_VAL, 4'b0000, value driven on {IN4,IN3,IN2,IN1} while not running.

Ports:
- CLK  input  1  clock, rising edge.
- RSTB  input  1  synchronous active-low reset.
- START  input  1  run request; sampled only in IDLE.
- MODE  input  2  pattern select, captured at START.
- NCYC  input  16  number of vectors to apply, captured at START.
- Q  input  1  output of the downstream AND4 cell; used only with the check feature.
- IN1  output  1  cell input bit 0.
- IN2  output  1  cell input bit 1.
- IN3  output  1  cell input bit 2.
- IN4  output  1  cell input bit 3.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse at end of run.
- ERR_CNT  output  8  saturating mismatch count.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: RSTB sampled low at a CLK rising edge resets the block. Ports are named CLK and RSTB.
- Reset values: state=IDLE, {IN4..IN1}=IDLE_VAL, BUSY=0, DONE=0, ERR_CNT=0, vector counter=0, LFSR=seed.
- A reset asserted mid-run aborts immediately. No DONE pulse is produced and ERR_CNT clears.
- States:
  - IDLE -> RUN when START=1 and NCYC!=0.
  - IDLE -> FIN when START=1 and NCYC==0.
  - RUN -> FIN when the vector counter reaches NCYC-1 on the current edge.
  - FIN -> IDLE unconditionally.
- START is ignored outside IDLE. START held high re-triggers a new run from IDLE on the cycle after FIN.
- Latency: START sampled at edge t. Vector k (k=0..NCYC-1) is on IN* during the cycle following edge t+1+k. DONE=1 during the cycle following edge t+NCYC+1 (FIN). IN* return to IDLE_VAL at entry to FIN. BUSY=1 exactly in RUN.
- Vector bit mapping: vector bit0 -> IN1, bit1 -> IN2, bit2 -> IN3, bit3 -> IN4.
- MODE 0, exhaustive: vector k = k mod 16, wrapping 4'hF -> 4'h0.
- MODE 1, random:
  - vector = LFSR[3:0].
  - LFSR is Fibonacci, taps 16,14,13,11, and advances once per vector.
  - LFSR reloads the seed at each START, so the sequence is repeatable.
- MODE 2, walking zero (maximizes Q toggles):
  - even k -> 4'hF.
  - odd k -> 4'hF with bit ((k>>1) mod 4) cleared.
  - Sequence: F,E,F,D,F,B,F,7,F,E...
- MODE 3, static: vector = 4'hF every cycle (leakage/hold measurement).
- The vector counter is 16 bits. NCYC=16'hFFFF is legal and produces 65535 vectors with no overflow.
- MODE and NCYC changes during RUN have no effect.

Optional Feature:
- Macro: AND4_STIM_CHECK_EN.
- Defined:
  - Q is sampled at each edge while a vector is being applied (edges t+2 .. t+NCYC+1).
  - The sample is compared with the AND of the vector driven in the preceding cycle.
  - Each mismatch increments ERR_CNT, saturating at 8'hFF.
  - ERR_CNT clears on an accepted START and holds its value after DONE until the next START or reset.
- Not defined: Q is ignored, ERR_CNT is constant 0, and no compare logic is generated. Port list is unchanged.

Test Plan:
- Reset: drive RSTB=0 for 2 cycles with START=1 -> IN*=IDLE_VAL, BUSY=0, DONE=0, ERR_CNT=0; no run starts.
- Exhaustive: MODE=0, NCYC=20, START pulse -> IN* sequence 0..F,0,1,2,3; BUSY high 20 cycles; DONE one pulse 21 edges after START; IN* back to 0.
- Walking zero with check: macro on, ideal AND4 model on Q, MODE=2, NCYC=8 -> vectors F,E,F,D,F,B,F,7; Q=1,0,1,0,1,0,1,0; ERR_CNT=0.
- Fault injection: macro on, Q forced 0, MODE=3, NCYC=300 -> ERR_CNT saturates at 8'hFF; next START clears it to 0.
- Boundaries:
  - NCYC=0 -> DONE pulses 1 cycle after START and BUSY stays 0.
  - START pulsed mid-run -> ignored, run length unchanged.
  - RSTB low mid-run -> no DONE, outputs at reset values next cycle.
- Repeatability: MODE=1, NCYC=16, two back-to-back runs -> identical IN* sequences; the first vector equals LFSR_SEED[3:0] (4'h1 for the default seed).
